mul_seq_4to2: RTL
=================

# mul_seq_4to2

Iterative unsigned multiplier controller that sequences a carry-save accumulator built from a row of 4-to-2 compressors. It retires two multiplier bits per cycle and resolves the carry-save pair with one final carry-propagate add. It sits between an operand producer and a result consumer using valid/ready handshakes on both sides. It is the area-cheap alternative to a full compressor-tree multiplier.

## Interface
- `WIDTH`, default 16: operand width in bits; must be even and ≥ 4 (elaboration-time `$error` otherwise).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  WIDTH  multiplicand, unsigned.
- `in_b`  in  WIDTH  multiplier, unsigned.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer accepts product.
- `out_prod`  out  2*WIDTH  unsigned product `in_a*in_b`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, COMPRESS, RESOLVE, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, latch `in_a` into reg A and `in_b` into reg B, clear S and C (both 2*WIDTH), clear step counter, go to COMPRESS.
- COMPRESS: step i = 0 .. WIDTH/2-1, one step per cycle.
  - pp0 = (A & {WIDTH{B[2i]}}) << 2i.
  - pp1 = (A & {WIDTH{B[2i+1]}}) << (2i+1). Both are zero-extended to 2*WIDTH.
  - Compressor column j takes data = {pp1[j], pp0[j], C[j], S[j]}.
  - Compressor cin[j] = cout[1] of column j-1; cin[0]=0.
  - Next S = sum vector. Next C = cout[0] vector << 1.
  - All carries out of bit 2*WIDTH-1 are discarded. The arithmetic is modulo 2^(2*WIDTH), which is exact because the product fits.
  - After step WIDTH/2-1, go to RESOLVE.
- RESOLVE: `out_prod` ← S + C (2*WIDTH-bit add, carry-out dropped); go to DONE.
- DONE: `out_valid`=1 and `out_prod` held stable. On `out_ready`, go to IDLE. `out_prod` keeps its value until the next RESOLVE.
- Operand inputs are ignored outside the IDLE accept cycle. `in_valid` while busy is not accepted.
- No overlap: a new operation is accepted only in IDLE, the cycle after the output handshake at the earliest.

## Timing
- Reset (asynchronous assert, synchronous deassert handled externally):
  - state=IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0, `out_prod`=0.
  - A, B, S, C and the counter are all 0.
- Latency: with an accept at edge k, `out_valid` rises after edge k+WIDTH/2+1. For WIDTH=16 that is 9 cycles.
- Throughput with `out_ready` held high: one product per WIDTH/2+3 cycles.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Reset mid-operation: the operation is aborted, no `out_valid` pulse is produced, and the block returns to the reset values above.
- The step counter is $clog2(WIDTH/2) bits wide and does not wrap within a valid operation. The transition to RESOLVE is decided on counter == WIDTH/2-1.

## Structure
- Package `mul_seq_pkg`:
  - state enum `mul_seq_state_e` {IDLE, COMPRESS, RESOLVE, DONE}.
  - function `steps(width)` = width/2.
- Sub-module `csa_row_4to2` (parameter N = 2*WIDTH): purely combinational; a generate loop of the existing `cmprs_4to2` cell with the cin chain. It outputs the sum vector and the shifted carry vector.
- The top level holds the FSM, the counter, the A/B/S/C registers, the partial-product generation and the final adder.

## Test plan
- WIDTH=16, a=0xFFFF, b=0xFFFF, `out_ready`=1 → `out_prod`=0xFFFE0001; `out_valid` high exactly 9 cycles after the accept edge, for one cycle.
- a=0x1234, b=0x0000, then a=0x0001, b=0x8000 → products 0x00000000 and 0x00008000; `in_ready` low from accept until the cycle after each output handshake.
- `out_ready` held low for 5 cycles in DONE (a=0x00FF, b=0x0101) → `out_prod`=0x0000FFFF stable throughout; `in_valid`=1 with new operands is not accepted; the next operation starts only after the handshake.
- Operands toggled every cycle during COMPRESS, with `in_valid` high the whole time → result equals the product of the operands present at the accept edge only.
- `rst_n` pulsed low during COMPRESS step 3 → all outputs reach reset values immediately and no `out_valid`; after release, a=3, b=5 gives 15 with normal latency.
- WIDTH=4 and WIDTH=32 builds, 1000 random operand pairs each with random `in_valid`/`out_ready` gaps → every product matches a behavioural `a*b` model and no result is dropped or duplicated.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared state type and step helper for the sequential 4:2 multiplier
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPRESS,
    RESOLVE,
    DONE
  } mul_seq_state_e;

  function automatic int steps(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/cmprs_4to2.sv
// rtl/cmprs_4to2.sv - 4-to-2 compressor cell built from two chained full adders
module cmprs_4to2 (
  input  logic [3:0] i_data,
  input  logic       i_cin,
  output logic       o_sum,
  output logic [1:0] o_cout
);

  logic w_s1;

  // o_cout[1] never depends on i_cin, so the row's cin chain does not ripple
  assign w_s1      = i_data[0] ^ i_data[1] ^ i_data[2];
  assign o_cout[1] = (i_data[0] & i_data[1]) | (i_data[0] & i_data[2]) | (i_data[1] & i_data[2]);
  assign o_sum     = w_s1 ^ i_data[3] ^ i_cin;
  assign o_cout[0] = (w_s1 & i_data[3]) | (w_s1 & i_cin) | (i_data[3] & i_cin);

endmodule

// File: rtl/csa_row_4to2.sv
// rtl/csa_row_4to2.sv - one row of 4:2 compressors folding two partial products into a carry-save pair
module csa_row_4to2 #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_s,
  input  logic [N-1:0] i_c,
  input  logic [N-1:0] i_pp0,
  input  logic [N-1:0] i_pp1,
  output logic [N-1:0] o_sum,
  output logic [N-1:0] o_carry
);

  logic [N-1:0] w_cout0;
  logic [N-1:0] w_cout1;
  logic [N-1:0] w_cin;
  logic [1:0]   w_unused_top;

  assign w_cin = {w_cout1[N-2:0], 1'b0};

  for (genvar j = 0; j < N; j++) begin : g_col
    cmprs_4to2 u_cell (
      .i_data ({i_pp1[j], i_pp0[j], i_c[j], i_s[j]}),
      .i_cin  (w_cin[j]),
      .o_sum  (o_sum[j]),
      .o_cout ({w_cout1[j], w_cout0[j]})
    );
  end

  // carries leaving the top column fall outside the modulo-2^N result
  assign o_carry      = {w_cout0[N-2:0], 1'b0};
  assign w_unused_top = {w_cout1[N-1], w_cout0[N-1]};

endmodule

// File: rtl/mul_seq_4to2.sv
// rtl/mul_seq_4to2.sv - iterative unsigned multiplier retiring two multiplier bits per cycle
module mul_seq_4to2
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  localparam int STEPS = steps(WIDTH);
  localparam int CW    = $clog2(STEPS);
  localparam int PW    = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("mul_seq_4to2: WIDTH must be even and >= 4");
  end

  mul_seq_state_e r_state;
  mul_seq_state_e w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_s;
  logic [PW-1:0]    r_c;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_prod;

  logic [PW-1:0]    w_pp0;
  logic [PW-1:0]    w_pp1;
  logic [PW-1:0]    w_sum;
  logic [PW-1:0]    w_carry;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = COMPRESS;
      end
      COMPRESS: if (r_cnt == LAST_STEP) w_next = RESOLVE;
      RESOLVE:  w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // the step counter selects multiplier bit pair 2i/2i+1 and its shift
  always_comb begin
    w_pp0 = '0;
    w_pp1 = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (r_cnt == CW'(k)) begin
        w_pp0 = PW'(r_a & {WIDTH{r_b[2*k]}}) << (2 * k);
        w_pp1 = PW'(r_a & {WIDTH{r_b[2*k+1]}}) << (2 * k + 1);
      end
    end
  end

  csa_row_4to2 #(
    .N (PW)
  ) u_row (
    .i_s     (r_s),
    .i_c     (r_c),
    .i_pp0   (w_pp0),
    .i_pp1   (w_pp1),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_c     <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_s   <= '0;
            r_c   <= '0;
            r_cnt <= '0;
          end
        end
        COMPRESS: begin
          r_s <= w_sum;
          r_c <= w_carry;
          if (r_cnt != LAST_STEP) r_cnt <= r_cnt + CW'(1);
        end
        RESOLVE: r_prod <= r_s + r_c;
        default: ;
      endcase
    end
  end

  assign out_prod = r_prod;

endmodule
